// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: instruction/PC widths, reset vector, buffer sizing and the
// derived pointer/counter types used by fetch_unit and fetch_buffer.
package fetch_unit_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 18;
  localparam int unsigned PC_WIDTH          = 14;
  localparam logic [PC_WIDTH-1:0] RESET_PC  = 14'h2000;

  // Must be a power of two, >= 2, so that pointers wrap naturally.
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned PTR_WIDTH = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  typedef logic [PC_WIDTH-1:0]          pc_t;
  typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;
  typedef logic [PTR_WIDTH-1:0]         ptr_t;
  typedef logic [CNT_WIDTH-1:0]         cnt_t;
  // One extra bit so in-flight arithmetic cannot wrap before it is truncated.
  typedef logic [CNT_WIDTH:0]           wide_cnt_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular reservation buffer for the fetch stage.
// Entries are allocated in request order (tail), filled in response order (fill pointer) and
// popped in order (head). Each entry carries its PC, instruction word and a filled bit.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               drop every entry and reset all pointers (overrides alloc/fill/pop)
//   i_alloc, i_alloc_pc   reserve the tail entry for a granted request at this PC
//   i_fill, i_fill_instr  write the oldest unfilled entry
//   i_pop                 retire the head entry
//   o_head_valid          head entry allocated and filled
//   o_head_pc/instr       head entry contents
//   o_alloc_cnt           number of allocated entries
//   o_unfilled_cnt        number of allocated entries still awaiting a response
// The caller guarantees alloc only when not full, fill only when an entry is unfilled and pop only
// when the head is valid.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_flush,
  input  logic   i_alloc,
  input  pc_t    i_alloc_pc,
  input  logic   i_fill,
  input  instr_t i_fill_instr,
  input  logic   i_pop,
  output logic   o_head_valid,
  output pc_t    o_head_pc,
  output instr_t o_head_instr,
  output cnt_t   o_alloc_cnt,
  output cnt_t   o_unfilled_cnt
);

  pc_t                  pc_q    [BUF_DEPTH];
  instr_t               instr_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled_q, filled_d;
  ptr_t                 head_q, head_d;
  ptr_t                 fill_q, fill_d;
  ptr_t                 tail_q, tail_d;
  cnt_t                 alloc_cnt_q, alloc_cnt_d;
  cnt_t                 unfilled_q, unfilled_d;

  always_comb begin
    filled_d    = filled_q;
    head_d      = head_q;
    fill_d      = fill_q;
    tail_d      = tail_q;
    alloc_cnt_d = alloc_cnt_q;
    unfilled_d  = unfilled_q;
    if (i_flush) begin
      filled_d    = '0;
      head_d      = '0;
      fill_d      = '0;
      tail_d      = '0;
      alloc_cnt_d = '0;
      unfilled_d  = '0;
    end else begin
      // Tail, fill and head never address the same entry in one cycle under the caller contract.
      if (i_alloc) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + ptr_t'(1);
      end
      if (i_fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + ptr_t'(1);
      end
      if (i_pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + ptr_t'(1);
      end
      alloc_cnt_d = alloc_cnt_q + cnt_t'(i_alloc) - cnt_t'(i_pop);
      unfilled_d  = unfilled_q + cnt_t'(i_alloc) - cnt_t'(i_fill);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q    <= '0;
      head_q      <= '0;
      fill_q      <= '0;
      tail_q      <= '0;
      alloc_cnt_q <= '0;
      unfilled_q  <= '0;
    end else begin
      if (i_alloc && !i_flush) pc_q[tail_q] <= i_alloc_pc;
      if (i_fill && !i_flush) instr_q[fill_q] <= i_fill_instr;
      filled_q    <= filled_d;
      head_q      <= head_d;
      fill_q      <= fill_d;
      tail_q      <= tail_d;
      alloc_cnt_q <= alloc_cnt_d;
      unfilled_q  <= unfilled_d;
    end
  end

  assign o_head_valid   = (alloc_cnt_q != '0) && filled_q[head_q];
  assign o_head_pc      = pc_q[head_q];
  assign o_head_instr   = instr_q[head_q];
  assign o_alloc_cnt    = alloc_cnt_q;
  assign o_unfilled_cnt = unfilled_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Walks sequential PCs, issues in-order requests to instruction memory,
// parks {pc, instr} in a reservation buffer and hands them to decode over valid/ready. A redirect
// flushes the buffer, restarts at the target and discards responses still in flight.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr, i_imem_gnt request channel (req & gnt = accepted)
//   i_imem_rvalid, i_imem_rdata         in-order response channel
//   i_redirect, i_redirect_pc           branch taken: flush and restart at target
//   o_id_valid, i_id_ready              decode handshake (valid & ready = pop)
//   o_id_instr, o_id_pc                 head instruction and its PC
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  output logic   o_imem_req,
  output pc_t    o_imem_addr,
  input  logic   i_imem_gnt,
  input  logic   i_imem_rvalid,
  input  instr_t i_imem_rdata,
  input  logic   i_redirect,
  input  pc_t    i_redirect_pc,
  output logic   o_id_valid,
  input  logic   i_id_ready,
  output instr_t o_id_instr,
  output pc_t    o_id_pc
);

  pc_t       pc_q, pc_d;
  cnt_t      drop_cnt_q, drop_cnt_d;
  cnt_t      alloc_cnt;
  cnt_t      unfilled_cnt;
  logic      head_valid;
  logic      gnt_fire;
  logic      fill;
  logic      pop;
  wide_cnt_t in_flight;

  // Gating with i_rst_n keeps req low while reset is held; the buffer alone would read as empty.
  assign o_imem_req  = i_rst_n && !i_redirect && (alloc_cnt < cnt_t'(BUF_DEPTH));
  assign o_imem_addr = pc_q;
  assign gnt_fire    = o_imem_req && i_imem_gnt;
  assign fill        = i_imem_rvalid && (drop_cnt_q == '0) && (unfilled_cnt != '0);
  assign pop         = head_valid && i_id_ready && !i_redirect;

  // Everything granted and not yet answered: earlier wrong-path requests plus live unfilled
  // entries, adjusted for this cycle's grant and response.
  assign in_flight = wide_cnt_t'(drop_cnt_q) + wide_cnt_t'(unfilled_cnt)
                   + wide_cnt_t'(gnt_fire) - wide_cnt_t'(i_imem_rvalid);

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (i_redirect) begin
      pc_d       = i_redirect_pc;
      drop_cnt_d = cnt_t'(in_flight);
    end else begin
      if (gnt_fire) pc_d = pc_q + pc_t'(1);
      if (i_imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_redirect),
    .i_alloc        (gnt_fire),
    .i_alloc_pc     (pc_q),
    .i_fill         (fill),
    .i_fill_instr   (i_imem_rdata),
    .i_pop          (pop),
    .o_head_valid   (head_valid),
    .o_head_pc      (o_id_pc),
    .o_head_instr   (o_id_instr),
    .o_alloc_cnt    (alloc_cnt),
    .o_unfilled_cnt (unfilled_cnt)
  );

  assign o_id_valid = head_valid;

  // A response must always have a request waiting for it, live or wrong-path.
  a_rvalid_has_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imem_rvalid |-> ((drop_cnt_q != '0) || (unfilled_cnt != '0)));

endmodule
